// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage -- RV64 memory-access pipeline stage (sits directly after EX).
//
// Takes the EX result (ALU value or effective address) and either forwards it
// as a write-back packet (non-memory ops) or runs one load/store over a
// req/gnt/rvalid data-memory port. EX is stalled (o_ex_ready low) whenever the
// stage is not idle. All outputs are registered.
//
// Ports
//   i_clk, i_rst           clock; synchronous active-high reset
//   i_ex_*                 op from EX (valid, result/address, store data,
//                          load/store flags, size, unsigned, rd addr/enable)
//   o_ex_ready             stage can accept an op (state is IDLE)
//   o_dmem_req/we/addr     dword-aligned request, held until i_dmem_gnt
//   o_dmem_wdata/wstrb     lane-shifted store data and byte enables
//   i_dmem_gnt/rvalid/rdata  grant, load-data valid, full dword read data
//   o_wb_valid/rd_addr/rd_wen/rd_data  one-cycle write-back packet
//   o_misalign             misaligned-access pulse
//
// Build option
//   MEM_STAGE_MISALIGN_TRAP_EN  when defined, a misaligned load/store issues
//   no memory request; it completes the next cycle with o_wb_valid=1,
//   o_wb_rd_wen=0 and o_misalign=1. When undefined, o_misalign is always 0
//   and misaligned accesses are issued with bytes past lane 7 dropped.
// -----------------------------------------------------------------------------
module mem_stage #(
  parameter int XLEN       = 64,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_ex_valid,
  output logic                  o_ex_ready,
  input  logic [XLEN-1:0]       i_ex_alu_result,
  input  logic [XLEN-1:0]       i_ex_store_data,
  input  logic                  i_ex_mem_rd,
  input  logic                  i_ex_mem_wr,
  input  logic [1:0]            i_ex_mem_size,
  input  logic                  i_ex_mem_unsigned,
  input  logic [REG_ADDR_W-1:0] i_ex_rd_addr,
  input  logic                  i_ex_rd_wen,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [XLEN-1:0]       o_dmem_addr,
  output logic [XLEN-1:0]       o_dmem_wdata,
  output logic [7:0]            o_dmem_wstrb,
  input  logic                  i_dmem_gnt,
  input  logic                  i_dmem_rvalid,
  input  logic [XLEN-1:0]       i_dmem_rdata,
  output logic                  o_wb_valid,
  output logic [REG_ADDR_W-1:0] o_wb_rd_addr,
  output logic                  o_wb_rd_wen,
  output logic [XLEN-1:0]       o_wb_rd_data,
  output logic                  o_misalign
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  // Op fields captured at accept time
  logic                  r_is_load;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic [2:0]            r_off;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic                  r_rd_wen;

  // Registered outputs
  logic                  r_dmem_req;
  logic                  r_dmem_we;
  logic [XLEN-1:0]       r_dmem_addr;
  logic [XLEN-1:0]       r_dmem_wdata;
  logic [7:0]            r_dmem_wstrb;
  logic                  r_wb_valid;
  logic [REG_ADDR_W-1:0] r_wb_rd_addr;
  logic                  r_wb_rd_wen;
  logic [XLEN-1:0]       r_wb_rd_data;
  logic                  r_misalign;

  logic                  w_accept;
  logic                  w_is_mem;
  logic                  w_is_store;
  logic                  w_rd_wen;
  logic                  w_trap;
  logic [2:0]            w_off;
  logic [7:0]            w_strb_base;
  logic [7:0]            w_strb;
  logic [XLEN-1:0]       w_wdata;
  logic [XLEN-1:0]       w_ld_shift;
  logic [XLEN-1:0]       w_ld_data;

  assign w_accept   = i_ex_valid && (r_state == S_IDLE);
  assign w_is_mem   = i_ex_mem_rd | i_ex_mem_wr;
  // Both flags set is treated as a load.
  assign w_is_store = i_ex_mem_wr & ~i_ex_mem_rd;
  // Writes to x0 are never reported as enabled.
  assign w_rd_wen   = i_ex_rd_wen & (i_ex_rd_addr != '0);
  assign w_off      = i_ex_alu_result[2:0];

  // Lane placement; shifting left naturally drops bytes past lane 7.
  assign w_wdata = i_ex_store_data << {w_off, 3'b000};
  assign w_strb  = w_strb_base << w_off;

  // NOTE: every signal written in an always_comb gets a default first, so no
  // path through the block can leave it unassigned and infer a latch.
  always_comb begin
    w_strb_base = 8'h01;
    case (i_ex_mem_size)
      2'b01:   w_strb_base = 8'h03;
      2'b10:   w_strb_base = 8'h0F;
      2'b11:   w_strb_base = 8'hFF;
      default: w_strb_base = 8'h01;
    endcase
  end

`ifdef MEM_STAGE_MISALIGN_TRAP_EN
  logic w_misaligned;

  always_comb begin
    w_misaligned = 1'b0;
    case (i_ex_mem_size)
      2'b01:   w_misaligned = w_off[0];
      2'b10:   w_misaligned = |w_off[1:0];
      2'b11:   w_misaligned = |w_off;
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_trap = w_is_mem & w_misaligned;
`else
  assign w_trap = 1'b0;
`endif

  // Load extraction: bring the addressed byte to lane 0, then size/extend.
  // Bytes beyond lane 7 shift in as zero.
  assign w_ld_shift = i_dmem_rdata >> {r_off, 3'b000};

  always_comb begin
    w_ld_data = w_ld_shift;
    case (r_size)
      2'b00:   w_ld_data = {{(XLEN-8){~r_unsigned & w_ld_shift[7]}},   w_ld_shift[7:0]};
      2'b01:   w_ld_data = {{(XLEN-16){~r_unsigned & w_ld_shift[15]}}, w_ld_shift[15:0]};
      2'b10:   w_ld_data = {{(XLEN-32){~r_unsigned & w_ld_shift[31]}}, w_ld_shift[31:0]};
      default: w_ld_data = w_ld_shift;
    endcase
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_is_mem && !w_trap) ? S_REQ : S_RESP;
      S_REQ:  if (i_dmem_gnt) w_next = r_is_load ? S_WAIT : S_RESP;
      S_WAIT: if (i_dmem_rvalid) w_next = S_RESP;
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // NOTE: these op-field registers are only read after an accept has loaded
  // them, so they carry no reset; that keeps the reset net off the datapath.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_is_load  <= i_ex_mem_rd;
      r_size     <= i_ex_mem_size;
      r_unsigned <= i_ex_mem_unsigned;
      r_off      <= w_off;
      r_rd_addr  <= i_ex_rd_addr;
      r_rd_wen   <= w_rd_wen;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_dmem_wstrb <= '0;
      r_wb_valid   <= 1'b0;
      r_wb_rd_addr <= '0;
      r_wb_rd_wen  <= 1'b0;
      r_wb_rd_data <= '0;
      r_misalign   <= 1'b0;
    end else begin
      // Write-back and misalign are single-cycle pulses.
      r_wb_valid <= 1'b0;
      r_misalign <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_is_mem && !w_trap) begin
              r_dmem_req   <= 1'b1;
              r_dmem_we    <= w_is_store;
              r_dmem_addr  <= {i_ex_alu_result[XLEN-1:3], 3'b000};
              r_dmem_wdata <= w_is_store ? w_wdata : '0;
              r_dmem_wstrb <= w_strb;
            end else begin
              // Non-memory op, or a trapped misaligned access.
              r_wb_valid   <= 1'b1;
              r_wb_rd_addr <= i_ex_rd_addr;
              r_wb_rd_wen  <= w_rd_wen & ~w_trap;
              r_wb_rd_data <= w_trap ? '0 : i_ex_alu_result;
              r_misalign   <= w_trap;
            end
          end
        end
        S_REQ: begin
          if (i_dmem_gnt) begin
            r_dmem_req <= 1'b0;
            if (!r_is_load) begin
              r_wb_valid   <= 1'b1;
              r_wb_rd_addr <= r_rd_addr;
              r_wb_rd_wen  <= 1'b0;
              r_wb_rd_data <= '0;
            end
          end
        end
        S_WAIT: begin
          if (i_dmem_rvalid) begin
            r_wb_valid   <= 1'b1;
            r_wb_rd_addr <= r_rd_addr;
            r_wb_rd_wen  <= r_rd_wen;
            r_wb_rd_data <= w_ld_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_ex_ready   = (r_state == S_IDLE);
  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_dmem_wstrb = r_dmem_wstrb;
  assign o_wb_valid   = r_wb_valid;
  assign o_wb_rd_addr = r_wb_rd_addr;
  assign o_wb_rd_wen  = r_wb_rd_wen;
  assign o_wb_rd_data = r_wb_rd_data;
  assign o_misalign   = r_misalign;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage -- self-checking bench for mem_stage.
//
// A transaction-level driver issues one op at a time (directed cases, then
// random ops with random grant/read-data delays and noise on gnt/rvalid where
// the stage must ignore them). For every cycle it publishes what the outputs
// must be, computed from byte-lane arithmetic; a single compare process checks
// the DUT against that on the falling edge. A few literal expectations pin the
// model itself.
// -----------------------------------------------------------------------------
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [63:0] ex_alu_result, ex_store_data;
  logic        ex_mem_rd, ex_mem_wr, ex_mem_unsigned, ex_rd_wen;
  logic [1:0]  ex_mem_size;
  logic [4:0]  ex_rd_addr;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [63:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [7:0]  dmem_wstrb;
  logic        wb_valid, wb_rd_wen, misalign;
  logic [4:0]  wb_rd_addr;
  logic [63:0] wb_rd_data;

  always #5 clk = ~clk;

  mem_stage dut (
    .i_clk(clk), .i_rst(rst),
    .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
    .i_ex_alu_result(ex_alu_result), .i_ex_store_data(ex_store_data),
    .i_ex_mem_rd(ex_mem_rd), .i_ex_mem_wr(ex_mem_wr),
    .i_ex_mem_size(ex_mem_size), .i_ex_mem_unsigned(ex_mem_unsigned),
    .i_ex_rd_addr(ex_rd_addr), .i_ex_rd_wen(ex_rd_wen),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_wstrb(dmem_wstrb),
    .i_dmem_gnt(dmem_gnt), .i_dmem_rvalid(dmem_rvalid), .i_dmem_rdata(dmem_rdata),
    .o_wb_valid(wb_valid), .o_wb_rd_addr(wb_rd_addr), .o_wb_rd_wen(wb_rd_wen),
    .o_wb_rd_data(wb_rd_data), .o_misalign(misalign)
  );

  typedef struct {
    logic [63:0] alu;
    logic [63:0] sdata;
    logic        rd;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rda;
    logic        wen;
  } op_t;

  int n_cmp = 0;
  int n_err = 0;

  // Expected per-cycle outputs, published by the driver
  logic        chk_en = 1'b0;
  logic        exp_ready, exp_req, exp_we, exp_wb, exp_wb_wen, exp_mis, exp_wb_dchk;
  logic [63:0] exp_addr, exp_wdata, exp_wb_data;
  logic [7:0]  exp_wstrb;
  logic [4:0]  exp_wb_addr;

  // Observations for the literal checks
  int          wb_count  = 0;
  int          req_count = 0;
  logic [63:0] last_addr, last_wdata, last_wb_data;
  logic [7:0]  last_wstrb;
  logic        last_we, last_wb_wen, last_mis;
  logic [4:0]  last_wb_addr;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model (byte-lane arithmetic) ----------------
  function automatic int nbytes(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic logic [63:0] m_wdata(input logic [63:0] sd, input logic [2:0] off);
    logic [63:0] r = '0;
    int o = int'(off);
    for (int j = 0; j < 8; j++)
      if (j >= o) r[8*j +: 8] = sd[8*(j-o) +: 8];
    return r;
  endfunction

  function automatic logic [7:0] m_wstrb(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] r = '0;
    int o = int'(off);
    for (int i = 0; i < nbytes(size); i++)
      if (o + i < 8) r[o+i] = 1'b1;
    return r;
  endfunction

  function automatic logic [63:0] m_load(input logic [63:0] rdata, input logic [1:0] size,
                                         input logic [2:0] off, input logic uns);
    logic [63:0] v = '0;
    int o = int'(off);
    int n = nbytes(size);
    for (int i = 0; i < n; i++)
      if (o + i < 8) v[8*i +: 8] = rdata[8*(o+i) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  function automatic logic m_trap(input op_t op);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    return (op.rd | op.wr) && ((int'(op.alu[2:0]) % nbytes(op.size)) != 0);
`else
    return 1'b0;
`endif
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("ex_ready", {63'd0, ex_ready}, {63'd0, exp_ready});
      check("dmem_req", {63'd0, dmem_req}, {63'd0, exp_req});
      if (exp_req) begin
        check("dmem_addr",  dmem_addr, exp_addr);
        check("dmem_we",    {63'd0, dmem_we}, {63'd0, exp_we});
        check("dmem_wstrb", {56'd0, dmem_wstrb}, {56'd0, exp_wstrb});
        if (exp_we) check("dmem_wdata", dmem_wdata, exp_wdata);
      end
      check("wb_valid", {63'd0, wb_valid}, {63'd0, exp_wb});
      if (exp_wb) begin
        check("wb_rd_addr", {59'd0, wb_rd_addr}, {59'd0, exp_wb_addr});
        check("wb_rd_wen",  {63'd0, wb_rd_wen}, {63'd0, exp_wb_wen});
        if (exp_wb_dchk) check("wb_rd_data", wb_rd_data, exp_wb_data);
      end
      check("misalign", {63'd0, misalign}, {63'd0, exp_wb & exp_mis});
    end
    if (dmem_req) begin
      req_count++;
      last_addr = dmem_addr; last_wdata = dmem_wdata;
      last_wstrb = dmem_wstrb; last_we = dmem_we;
    end
    if (wb_valid) begin
      wb_count++;
      last_wb_addr = wb_rd_addr; last_wb_wen = wb_rd_wen;
      last_wb_data = wb_rd_data; last_mis = misalign;
    end
  end

  // ---------------- driver ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_ex_fields();
    ex_alu_result   = {$urandom, $urandom};
    ex_store_data   = {$urandom, $urandom};
    ex_mem_rd       = 1'($urandom);
    ex_mem_wr       = 1'($urandom);
    ex_mem_size     = 2'($urandom);
    ex_mem_unsigned = 1'($urandom);
    ex_rd_addr      = 5'($urandom);
    ex_rd_wen       = 1'($urandom);
  endtask

  task automatic quiet_expect();
    exp_ready = 1'b1; exp_req = 1'b0; exp_wb = 1'b0; exp_mis = 1'b0;
  endtask

  task automatic idle_gap(input int n);
    for (int i = 0; i < n; i++) begin
      dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom);
      tick();
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex_ready"}, {63'd0, ex_ready}, 64'd1);
    check({tag, "_req"},      {63'd0, dmem_req}, 64'd0);
    check({tag, "_we"},       {63'd0, dmem_we}, 64'd0);
    check({tag, "_addr"},     dmem_addr, 64'd0);
    check({tag, "_wdata"},    dmem_wdata, 64'd0);
    check({tag, "_wstrb"},    {56'd0, dmem_wstrb}, 64'd0);
    check({tag, "_wb_valid"}, {63'd0, wb_valid}, 64'd0);
    check({tag, "_wb_addr"},  {59'd0, wb_rd_addr}, 64'd0);
    check({tag, "_wb_wen"},   {63'd0, wb_rd_wen}, 64'd0);
    check({tag, "_wb_data"},  wb_rd_data, 64'd0);
    check({tag, "_misalign"}, {63'd0, misalign}, 64'd0);
  endtask

  // One complete op. Called with the stage idle, just after a rising edge.
  task automatic do_op(input op_t op, input int gdly, input int rdly,
                       input logic [63:0] rdata, input bit rst_in_wait);
    logic mem  = op.rd | op.wr;
    logic st   = op.wr & ~op.rd;
    logic trap = m_trap(op);
    logic [2:0] off = op.alu[2:0];

    ex_valid = 1'b1;
    ex_alu_result = op.alu; ex_store_data = op.sdata;
    ex_mem_rd = op.rd; ex_mem_wr = op.wr; ex_mem_size = op.size;
    ex_mem_unsigned = op.uns; ex_rd_addr = op.rda; ex_rd_wen = op.wen;
    dmem_gnt = 1'($urandom); dmem_rvalid = 1'($urandom);
    quiet_expect();
    tick();
    ex_valid = 1'b0;
    randomize_ex_fields();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    exp_ready = 1'b0;

    if (!mem || trap) begin
      exp_wb = 1'b1; exp_wb_addr = op.rda; exp_mis = trap;
      exp_wb_wen = !trap && op.wen && (op.rda != 0);
      exp_wb_dchk = !trap; exp_wb_data = op.alu;
      tick();
      quiet_expect();
      return;
    end

    exp_req = 1'b1; exp_we = st;
    exp_addr = {op.alu[63:3], 3'b000};
    exp_wdata = m_wdata(op.sdata, off);
    exp_wstrb = m_wstrb(op.size, off);
    for (int i = 0; i < gdly; i++) begin
      dmem_rvalid = 1'($urandom);
      tick();
    end
    dmem_gnt = 1'b1; dmem_rvalid = 1'($urandom);
    tick();
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    exp_req = 1'b0;

    if (st) begin
      exp_wb = 1'b1; exp_wb_addr = op.rda; exp_wb_wen = 1'b0;
      exp_wb_dchk = 1'b1; exp_wb_data = 64'd0;
      tick();
      quiet_expect();
      return;
    end

    if (rst_in_wait) begin
      int wb_before;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      quiet_expect();
      check_all_zero("rst_mid");
      wb_before = wb_count;
      tick();
      dmem_rvalid = 1'b1; dmem_rdata = rdata;
      tick();
      dmem_rvalid = 1'b0;
      tick();
      check("rst_late_rvalid_wb", 64'(wb_count - wb_before), 64'd0);
      return;
    end

    for (int i = 0; i < rdly; i++) begin
      dmem_gnt = 1'($urandom);
      tick();
    end
    dmem_gnt = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rdata;
    tick();
    dmem_rvalid = 1'b0; dmem_rdata = {$urandom, $urandom};
    exp_wb = 1'b1; exp_wb_addr = op.rda; exp_wb_wen = op.wen && (op.rda != 0);
    exp_wb_dchk = 1'b1; exp_wb_data = m_load(rdata, op.size, off, op.uns);
    tick();
    quiet_expect();
  endtask

  function automatic op_t mk(input logic [63:0] alu, input logic [63:0] sd, input logic rd,
                             input logic wr, input logic [1:0] size, input logic uns,
                             input logic [4:0] rda, input logic wen);
    op_t o;
    o.alu = alu; o.sdata = sd; o.rd = rd; o.wr = wr;
    o.size = size; o.uns = uns; o.rda = rda; o.wen = wen;
    return o;
  endfunction

  initial begin
    int wb0, rq0;
    op_t op;

    rst = 1'b1; ex_valid = 1'b0; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    dmem_rdata = '0;
    randomize_ex_fields();
    quiet_expect();
    exp_we = 1'b0; exp_wb_wen = 1'b0; exp_wb_dchk = 1'b0;
    exp_addr = '0; exp_wdata = '0; exp_wstrb = '0; exp_wb_addr = '0; exp_wb_data = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_all_zero("reset");
    chk_en = 1'b1;

    // ALU op passes straight through
    do_op(mk(64'h1234, 64'd0, 1'b0, 1'b0, 2'b11, 1'b0, 5'd5, 1'b1), 0, 0, 64'd0, 1'b0);
    check("alu_wb_data", last_wb_data, 64'h1234);
    check("alu_wb_addr", {59'd0, last_wb_addr}, 64'd5);
    check("alu_wb_wen",  {63'd0, last_wb_wen}, 64'd1);

    // LB / LBU at byte 3 of a dword
    do_op(mk(64'h1003, 64'd0, 1'b1, 1'b0, 2'b00, 1'b0, 5'd9, 1'b1), 0, 0, 64'h8000_0000, 1'b0);
    check("lb_addr", last_addr, 64'h1000);
    check("lb_data", last_wb_data, 64'hFFFF_FFFF_FFFF_FF80);
    do_op(mk(64'h1003, 64'd0, 1'b1, 1'b0, 2'b00, 1'b1, 5'd9, 1'b1), 1, 2, 64'h8000_0000, 1'b0);
    check("lbu_data", last_wb_data, 64'h80);

    // SH into the top half-word
    do_op(mk(64'h2006, 64'hBEEF, 1'b0, 1'b1, 2'b01, 1'b0, 5'd3, 1'b1), 0, 0, 64'd0, 1'b0);
    check("sh_wdata", last_wdata, 64'hBEEF_0000_0000_0000);
    check("sh_wstrb", {56'd0, last_wstrb}, 64'hC0);
    check("sh_we",    {63'd0, last_we}, 64'd1);
    check("sh_wb_wen", {63'd0, last_wb_wen}, 64'd0);

    // Grant withheld for 3 cycles: exactly one write-back
    wb0 = wb_count;
    do_op(mk(64'h3010, 64'h55AA, 1'b0, 1'b1, 2'b10, 1'b0, 5'd4, 1'b1), 3, 0, 64'd0, 1'b0);
    check("gnt_wait_wb_count", 64'(wb_count - wb0), 64'd1);

    // Reset while waiting for read data
    do_op(mk(64'h4000, 64'd0, 1'b1, 1'b0, 2'b11, 1'b0, 5'd7, 1'b1), 0, 0, 64'hDEAD_BEEF, 1'b1);

    // LW at offset 2
    rq0 = req_count;
    do_op(mk(64'h1002, 64'd0, 1'b1, 1'b0, 2'b10, 1'b0, 5'd8, 1'b1), 0, 0, 64'h1122_3344_5566_7788, 1'b0);
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    check("lw_mis_flag", {63'd0, last_mis}, 64'd1);
    check("lw_mis_noreq", 64'(req_count - rq0), 64'd0);
    check("lw_mis_wen", {63'd0, last_wb_wen}, 64'd0);
`else
    check("lw_mis_req", 64'(req_count > rq0), 64'd1);
    check("lw_mis_wstrb", {56'd0, last_wstrb}, 64'h3C);
    check("lw_mis_data", last_wb_data, 64'h0000_0000_3344_5566);
`endif

    // Random ops
    for (int n = 0; n < 400; n++) begin
      op.alu = {$urandom, $urandom}; op.sdata = {$urandom, $urandom};
      if ($urandom_range(3) == 0) begin
        op.rd = 1'b0; op.wr = 1'b0;
      end else begin
        op.rd = 1'($urandom); op.wr = op.rd ? 1'($urandom) : 1'b1;
      end
      op.size = 2'($urandom); op.uns = 1'($urandom);
      op.rda = 5'($urandom); op.wen = 1'($urandom);
      do_op(op, $urandom_range(3), $urandom_range(3), {$urandom, $urandom}, 1'b0);
      idle_gap($urandom_range(2));
    end

    tick();
    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
